pipe_stage_buf: RTL and testbench

- Parametrised successor of the fixed EX→MEM latch: a generic inter-stage pipeline buffer carrying the instIdx / rdE / rdIdx / rdData bundle.
- Replaces the hard-wired stall-vector bits with a valid/ready handshake, a DEPTH-entry elastic queue (skid capacity), and a flush input.
- Presents an architectural NOP bundle downstream whenever it is empty.
- Sits between any two pipeline stages (EX→MEM, MEM→WB, ...).

---
 rtl/pipe_stage_buf_pkg.sv | 21 ++
 rtl/pipe_fifo_ctrl.sv | 65 ++++++
 rtl/pipe_stage_buf.sv | 94 +++++++++
 tb/tb_pipe_stage_buf.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the inter-stage pipeline buffer: NOP bundle encodings and default field widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_stage_buf_pkg;

  // Default field widths of the instIdx / rdIdx / rdData bundle
  localparam int INST_IDX_RANGE = 6;
  localparam int REG_IDX_RANGE  = 5;
  localparam int DATA_RANGE     = 32;

  // Architectural NOP bundle presented downstream while the buffer is empty
  localparam int unsigned ID_NOP        = 0;
  localparam int unsigned REG_NOP       = 0;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO32        = 32'h0000_0000;

  // Supported queue depth range
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

endpackage

// File: rtl/pipe_fifo_ctrl.sv
// Queue controller: read/write pointers, occupancy count, registered ready and flush handling.
// Latency: pointers/count update at the edge of the handshake; ready reflects the post-edge occupancy.
// Backpressure: up_ready is a register (next_count != DEPTH); no combinational path from dn_ready.
module pipe_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic             dn_ready,
  output logic             up_ready,
  output logic             dn_valid,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] next_count;

  // Explicit wrap compare keeps non-power-of-two depths legal
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push in a flush cycle is dropped, so it never touches the storage
  assign push     = up_valid & up_ready & ~flush;
  assign dn_valid = (count != '0);
  assign pop      = dn_valid & dn_ready;

  // Occupancy after this edge; a flush empties the queue regardless of handshakes
  always_comb begin
    next_count = count;
    if (flush) begin
      next_count = '0;
    end else begin
      next_count = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer, count and ready registers; reset outranks flush, flush outranks push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      up_ready <= 1'b1;
    end else if (flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      up_ready <= 1'b1;
    end else begin
      count    <= next_count;
      up_ready <= (next_count != CNT_W'(DEPTH));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage buffer for the instIdx/rdE/rdIdx/rdData bundle with DEPTH-entry elastic queue and flush.
// Latency: 1 cycle when empty (push at edge t visible after edge t); otherwise after all older entries pop.
// Backpressure: valid/ready; up_ready_out is registered, DEPTH>=2 sustains one transfer per cycle.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int INST_IDX_W = INST_IDX_RANGE,
  parameter int REG_IDX_W  = REG_IDX_RANGE,
  parameter int DATA_W     = DATA_RANGE,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush_in,
  input  logic                  up_valid_in,
  output logic                  up_ready_out,
  input  logic [INST_IDX_W-1:0] instIdx_in,
  input  logic                  rdE_in,
  input  logic [REG_IDX_W-1:0]  rdIdx_in,
  input  logic [DATA_W-1:0]     rdData_in,
  output logic                  dn_valid_out,
  input  logic                  dn_ready_in,
  output logic [INST_IDX_W-1:0] instIdx_out,
  output logic                  rdE_out,
  output logic [REG_IDX_W-1:0]  rdIdx_out,
  output logic [DATA_W-1:0]     rdData_out,
  output logic [CNT_W-1:0]      count_out
);

  // DEPTH is expected in DEPTH_MIN..DEPTH_MAX
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = INST_IDX_W + 1 + REG_IDX_W + DATA_W;

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    head;
  logic [INST_IDX_W-1:0] head_inst;
  logic                  head_rde;
  logic [REG_IDX_W-1:0]  head_rdidx;
  logic [DATA_W-1:0]     head_data;

  pipe_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clk      (clk_in),
    .rst      (rst_in),
    .flush    (flush_in),
    .up_valid (up_valid_in),
    .dn_ready (dn_ready_in),
    .up_ready (up_ready_out),
    .dn_valid (dn_valid_out),
    .push     (push),
    .pop      (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count_out)
  );

  // Storage is data-only and needs no reset; validity lives in the controller
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= {instIdx_in, rdE_in, rdIdx_in, rdData_in};
    end
  end

  assign head = mem[rd_ptr];
  assign {head_inst, head_rde, head_rdidx, head_data} = head;

  // Present the head entry, or the NOP bundle when empty so rdE never leaks without valid
  always_comb begin
    instIdx_out = INST_IDX_W'(ID_NOP);
    rdE_out     = WRITE_DISABLE;
    rdIdx_out   = REG_IDX_W'(REG_NOP);
    rdData_out  = DATA_W'(ZERO32);
    if (dn_valid_out) begin
      instIdx_out = head_inst;
      rdE_out     = head_rde;
      rdIdx_out   = head_rdidx;
      rdData_out  = head_data;
    end
  end

  // pop is consumed inside the controller; kept here for a readable handshake picture
  logic unused_pop;
  assign unused_pop = pop;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: DEPTH=2 instance, index 1: DEPTH=3 instance
  logic        rst      [2];
  logic        flush    [2];
  logic        up_valid [2];
  logic        up_ready [2];
  logic [5:0]  inst_in  [2];
  logic        rde_in   [2];
  logic [4:0]  idx_in   [2];
  logic [31:0] data_in  [2];
  logic        dn_valid [2];
  logic        dn_ready [2];
  logic [5:0]  inst_out [2];
  logic        rde_out  [2];
  logic [4:0]  idx_out  [2];
  logic [31:0] data_out [2];
  logic [1:0]  cnt_out  [2];

  int checks   = 0;
  int failures = 0;

  logic [5:0] q0 [$];
  logic [5:0] q1 [$];
  logic       last_acc;
  logic       last_pop;

  pipe_stage_buf #(.DEPTH(2)) dut2 (
    .clk_in(clk), .rst_in(rst[0]), .flush_in(flush[0]),
    .up_valid_in(up_valid[0]), .up_ready_out(up_ready[0]),
    .instIdx_in(inst_in[0]), .rdE_in(rde_in[0]), .rdIdx_in(idx_in[0]), .rdData_in(data_in[0]),
    .dn_valid_out(dn_valid[0]), .dn_ready_in(dn_ready[0]),
    .instIdx_out(inst_out[0]), .rdE_out(rde_out[0]), .rdIdx_out(idx_out[0]), .rdData_out(data_out[0]),
    .count_out(cnt_out[0])
  );

  pipe_stage_buf #(.DEPTH(3)) dut3 (
    .clk_in(clk), .rst_in(rst[1]), .flush_in(flush[1]),
    .up_valid_in(up_valid[1]), .up_ready_out(up_ready[1]),
    .instIdx_in(inst_in[1]), .rdE_in(rde_in[1]), .rdIdx_in(idx_in[1]), .rdData_in(data_in[1]),
    .dn_valid_out(dn_valid[1]), .dn_ready_in(dn_ready[1]),
    .instIdx_out(inst_out[1]), .rdE_out(rde_out[1]), .rdIdx_out(idx_out[1]), .rdData_out(data_out[1]),
    .count_out(cnt_out[1])
  );

  // Bundle fields derived from the instruction id so every field is checked
  function automatic logic f_rde(input logic [5:0] id);
    return id[0] | id[1];
  endfunction
  function automatic logic [4:0] f_idx(input logic [5:0] id);
    return id[4:0] ^ 5'h15;
  endfunction
  function automatic logic [31:0] f_data(input logic [5:0] id);
    return {8'hA5, 18'h0, id};
  endfunction

  task automatic chk(input string tag, input int s, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, s, obs, exp);
    end
  endtask

  // One clock cycle on instance s: drive, predict from the scoreboard, step, compare
  task automatic cyc(input int s, input logic r, input logic f, input logic v,
                     input logic [5:0] id, input logic dr);
    int depth;
    int mc;
    int sz;
    logic [5:0] h;
    depth = (s == 0) ? 2 : 3;
    rst[s] = r; flush[s] = f; up_valid[s] = v; dn_ready[s] = dr;
    inst_in[s] = id; rde_in[s] = f_rde(id); idx_in[s] = f_idx(id); data_in[s] = f_data(id);
    mc = (s == 0) ? q0.size() : q1.size();
    last_acc = !r && !f && v && (mc != depth);
    last_pop = !r && (mc != 0) && dr;
    @(posedge clk);
    #1;
    if (s == 0) begin
      if (r || f) q0.delete();
      else begin
        if (last_pop) void'(q0.pop_front());
        if (last_acc) q0.push_back(id);
      end
      sz = q0.size();
      h = (sz != 0) ? q0[0] : 6'd0;
    end else begin
      if (r || f) q1.delete();
      else begin
        if (last_pop) void'(q1.pop_front());
        if (last_acc) q1.push_back(id);
      end
      sz = q1.size();
      h = (sz != 0) ? q1[0] : 6'd0;
    end
    chk("count", s, 64'(cnt_out[s]), 64'(sz));
    chk("dn_valid", s, 64'(dn_valid[s]), 64'(sz != 0));
    chk("up_ready", s, 64'(up_ready[s]), 64'(sz != depth));
    chk("instIdx", s, 64'(inst_out[s]), 64'(h));
    chk("rdE", s, 64'(rde_out[s]), (sz != 0) ? 64'(f_rde(h)) : 64'd0);
    chk("rdIdx", s, 64'(idx_out[s]), (sz != 0) ? 64'(f_idx(h)) : 64'd0);
    chk("rdData", s, 64'(data_out[s]), (sz != 0) ? 64'(f_data(h)) : 64'd0);
    chk("rdE_without_valid", s, 64'(rde_out[s] & ~dn_valid[s]), 64'd0);
  endtask

  initial begin
    int sent;
    int got;
    logic [5:0] nid;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; flush[i] = 1'b0; up_valid[i] = 1'b0; dn_ready[i] = 1'b0;
      inst_in[i] = '0; rde_in[i] = 1'b0; idx_in[i] = '0; data_in[i] = '0;
    end

    // Reset held two cycles with a valid bundle offered
    cyc(0, 1'b1, 1'b0, 1'b1, 6'd3, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1, 6'd3, 1'b0);

    // Streaming: ids 1..8 back to back with downstream always ready
    for (int i = 1; i <= 8; i++) cyc(0, 1'b0, 1'b0, 1'b1, 6'(i), 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

    // Backpressure and skid: 5, 6 fill the buffer, 7 is refused, one pop exposes 6
    cyc(0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 6'd6, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b1, 6'd7, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Flush with two entries held while pushing 9; 9 must never appear
    cyc(0, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b1, 6'd9, 1'b0);
    cyc(0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

    // Empty pop attempts must not underflow
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

    // Reset mid-transfer discards held entries
    cyc(0, 1'b0, 1'b0, 1'b1, 6'd10, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b1, 6'd11, 1'b1);
    cyc(0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

    // Wrap with DEPTH=3: interleaved push/pop, random downstream readiness
    cyc(1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    nid = 6'd20;
    sent = 0;
    got = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      cyc(1, 1'b0, 1'b0, (sent < 10), nid, 1'($urandom_range(0, 1)));
      chk("wrap_count_le3", 1, 64'(cnt_out[1] <= 2'd3), 64'd1);
      if (last_acc) begin
        sent++;
        nid = nid + 6'd1;
      end
      if (last_pop) got++;
    end
    chk("wrap_all_popped", 1, 64'(got), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
